// File: rtl/pool_pkg.sv
// pool_pkg
//   Shared types and constants for the 2x2 / stride-2 max-pooling stage.
//   - state_t     : FSM encoding {IDLE, RD, WR, DONE}
//   - CSEL_*      : shared memory-select codes (L0 read, L1 write, none)
//   - *_DEF       : default geometry / data width
//   - FRAC_W      : fractional bits of the Q4.16 data format
//   - beat_offset : window beat -> address offset table {0, 1, IMG_W, IMG_W+1}
package pool_pkg;

  localparam int IMG_W_DEF = 64;
  localparam int DW_DEF    = 20;
  localparam int AW_DEF    = 12;
  localparam int FRAC_W    = 16;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  // Beat order inside a 2x2 window: top-left, top-right, bottom-left, bottom-right.
  function automatic int beat_offset(input int beat, input int img_w);
    case (beat)
      0:       return 0;
      1:       return 1;
      2:       return img_w;
      default: return img_w + 1;
    endcase
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen
//   Pure combinational L0 read-address generator for one pooling window beat.
//   The parent registers the result onto caddr_rd.
//   Ports:
//     idx  in  AW-2  output index {r, c}
//     beat in  2     beat within the 2x2 window (0..3)
//     addr out AW    L0 address = (2r)*IMG_W + 2c + beat_offset(beat)
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic [AW-3:0] idx,
  input  logic [1:0]    beat,
  output logic [AW-1:0] addr
);

  // Row and column fields of the output index each take half of its bits.
  localparam int HB = AW / 2 - 1;

  logic [HB-1:0] row;
  logic [HB-1:0] col;
  logic [AW-1:0] base;
  logic [AW-1:0] cand [4];

  assign row = idx[AW-3:HB];
  assign col = idx[HB-1:0];

  // {row,0,col,0} places 2*row at the IMG_W weight and 2*col at the unit weight,
  // which is (2r)*IMG_W + 2c without a multiplier.
  assign base = {row, 1'b0, col, 1'b0};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_beat
      assign cand[gi] = base + AW'(beat_offset(gi, IMG_W));
    end
  endgenerate

  assign addr = cand[beat];

endmodule

// File: rtl/pool_engine.sv
// pool_engine
//   2x2 / stride-2 max-pooling of the IMG_W x IMG_W layer-0 map (L0) into the
//   (IMG_W/2)^2 layer-1 map (L1), one pass per accepted ready request.
//   Each output costs 4 read beats (RD) plus 1 write beat (WR).
//   Optional build macro: POOL_CEIL_EN -- round the pooled value toward +inf
//   to an integer (4-bit integer part wraps) before writing it.
//   Ports:
//     clk       in   1    clock, posedge
//     reset     in   1    asynchronous, active-low
//     ready     in   1    start request, sampled only in IDLE
//     busy      out  1    high from accept until one cycle after the last write
//     crd       out  1    L0 read strobe
//     caddr_rd  out  AW   L0 read address
//     cdata_rd  in   DW   L0 read data, valid at the posedge ending the crd cycle
//     cwr       out  1    L1 write strobe
//     caddr_wr  out  AW   L1 write address
//     cdata_wr  out  DW   L1 write data
//     csel      out  3    memory select: 001 read, 011 write, 000 otherwise
module pool_engine
  import pool_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int IW = AW - 2;
  localparam logic [IW-1:0] IDX_LAST = '1;

  state_t        state_reg;
  logic [IW-1:0] idx_reg;
  logic [1:0]    beat_reg;
  logic [DW-1:0] max_reg;

  logic [IW-1:0] addr_idx;
  logic [1:0]    addr_beat;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] max_next;
  logic [DW-1:0] pooled_out;

  // Address of the beat that will be active in the next cycle, so caddr_rd can
  // be loaded as a register alongside the state change.
  always_comb begin
    addr_idx  = idx_reg;
    addr_beat = 2'd0;
    case (state_reg)
      RD:      addr_beat = beat_reg + 2'd1;
      WR:      addr_idx  = idx_reg + IW'(1);
      default: ;
    endcase
  end

  pool_addr_gen #(
    .IMG_W (IMG_W),
    .AW    (AW)
  ) u_addr_gen (
    .idx  (addr_idx),
    .beat (addr_beat),
    .addr (addr_next)
  );

  // Running signed maximum; beat 0 seeds it, ties keep the held value.
  always_comb begin
    if (beat_reg == 2'd0 || $signed(cdata_rd) > $signed(max_reg)) begin
      max_next = cdata_rd;
    end else begin
      max_next = max_reg;
    end
  end

`ifdef POOL_CEIL_EN
  logic [DW-FRAC_W-1:0] int_part;
  logic [DW-FRAC_W-1:0] int_inc;

  assign int_part = max_next[DW-1:FRAC_W];
  assign int_inc  = int_part + (DW - FRAC_W)'(1);

  // Any fractional bit set: next integer up (integer part wraps), else unchanged.
  always_comb begin
    if (max_next[FRAC_W-1:0] != '0) begin
      pooled_out = {int_inc, {FRAC_W{1'b0}}};
    end else begin
      pooled_out = max_next;
    end
  end
`else
  assign pooled_out = max_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      beat_reg  <= '0;
      max_reg   <= '0;
      busy      <= 1'b0;
      crd       <= 1'b0;
      cwr       <= 1'b0;
      csel      <= CSEL_NONE;
      caddr_rd  <= '0;
      caddr_wr  <= '0;
      cdata_wr  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ready) begin
            state_reg <= RD;
            busy      <= 1'b1;
            crd       <= 1'b1;
            csel      <= CSEL_L0;
            caddr_rd  <= addr_next;
            beat_reg  <= 2'd0;
          end
        end

        RD: begin
          max_reg  <= max_next;
          caddr_rd <= addr_next;
          beat_reg <= beat_reg + 2'd1;
          if (beat_reg == 2'd3) begin
            // Final beat: the compare result goes straight into the write
            // register so the write happens in the very next cycle.
            state_reg <= WR;
            crd       <= 1'b0;
            cwr       <= 1'b1;
            csel      <= CSEL_L1;
            caddr_wr  <= AW'(idx_reg);
            cdata_wr  <= pooled_out;
          end
        end

        WR: begin
          cwr     <= 1'b0;
          idx_reg <= idx_reg + IW'(1);
          if (idx_reg == IDX_LAST) begin
            // idx wraps to 0 here, ready for the next pass.
            state_reg <= DONE;
            csel      <= CSEL_NONE;
          end else begin
            state_reg <= RD;
            crd       <= 1'b1;
            csel      <= CSEL_L0;
            caddr_rd  <= addr_next;
          end
        end

        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
